sdram_arbiter: RTL

- Top-level resource scheduler for the single SDRAM command bus.
- Sequences power-up init, then grants the bus to one of three requesters: auto-refresh, write and read.
- Muxes the granted requester's cmd/addr/bank onto the SDRAM pins.
- Sits between the sdram_init / sdram_aref / sdram_write / sdram_read sub-controllers and the SDRAM device.

---
 rtl/sdram_pkg.sv | 39 +++
 rtl/sdram_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, bus widths and one-hot
// state encodings used by the arbiter and the sub-controllers.
package sdram_pkg;

    localparam int ADDR_W = 12;
    localparam int BA_W   = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARB   = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } arb_state_t;

    // Which of write/read owned the bus most recently.
    typedef enum logic {
        LAST_READ  = 1'b0,
        LAST_WRITE = 1'b1
    } rw_side_t;

    // One-hot states shared by the write and read sub-controllers.
    typedef enum logic [3:0] {
        XFER_IDLE = 4'b0001,
        XFER_ACT  = 4'b0010,
        XFER_DATA = 4'b0100,
        XFER_PRE  = 4'b1000
    } xfer_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Owns the single SDRAM command bus: waits for init, then grants it to
// refresh, write or read and muxes the owner's command onto the pins.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int         ADDR_W  = sdram_pkg::ADDR_W,
    parameter int         BA_W    = sdram_pkg::BA_W,
    parameter logic [3:0] CMD_NOP = sdram_pkg::CMD_NOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              ref_end,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    output logic              ref_en,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_bank,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_bank,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba
);

    arb_state_t state, state_next;
    rw_side_t   last_rw;

    // State register, last-owner tracking and registered grant pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            last_rw   <= LAST_READ;
            ref_en    <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            sdram_cke <= 1'b0;
        end else begin
            state     <= state_next;
            sdram_cke <= 1'b1;
            ref_en    <= (state == ST_ARB) && (state_next == ST_AREF);
            wr_en     <= (state == ST_ARB) && (state_next == ST_WRITE);
            rd_en     <= (state == ST_ARB) && (state_next == ST_READ);
            if (state == ST_WRITE && wr_end)
                last_rw <= LAST_WRITE;
            else if (state == ST_READ && rd_end)
                last_rw <= LAST_READ;
        end
    end

    // Next state: refresh first, then write/read alternating when both wait.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (init_end) state_next = ST_ARB;
            ST_ARB: begin
                if (ref_req)
                    state_next = ST_AREF;
                else if (wr_req && rd_req)
                    state_next = (last_rw == LAST_WRITE) ? ST_READ : ST_WRITE;
                else if (wr_req)
                    state_next = ST_WRITE;
                else if (rd_req)
                    state_next = ST_READ;
            end
            ST_AREF:  if (ref_end) state_next = ST_ARB;
            ST_WRITE: if (wr_end)  state_next = ST_ARB;
            ST_READ:  if (rd_end)  state_next = ST_ARB;
            default:  state_next = ST_INIT;
        endcase
    end

    // Bus mux driven purely by the current owner.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
        case (state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_ba   = wr_bank;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_bank;
            end
            default: ;
        endcase
    end

endmodule
